pos_to_mask_builder: RTL and testbench
======================================

Name: pos_to_mask_builder

Overview:
- Inverse of the team's lowest-set-bit position encoder.
- Accepts a stream of bit positions over a valid/ready handshake and expands each position to one-hot.
- ORs the one-hot values into an accumulator and, on the beat flagged last, presents the rebuilt WIDTH-bit mask on a registered valid/ready output.
- Sits between the position-compression path and downstream mask consumers.

Parameters:
- WIDTH, 8, mask width in bits; must be at least 2.
- POS_W, $clog2(WIDTH), width of the position field.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  position beat valid.
- in_ready  output  1  builder can accept a beat.
- in_pos  input  POS_W  bit position to set.
- in_none  input  1  beat carries no position (encoder default case); in_pos ignored.
- in_last  input  1  final beat of the current frame.
- out_valid  output  1  mask available.
- out_ready  input  1  downstream accepts the mask.
- out_mask  output  WIDTH  rebuilt mask.
- out_count  output  POS_W+1  number of distinct bits set in out_mask.
- err_range  output  1  sticky: a position >= WIDTH was received; cleared only by reset.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=ACCUM, accumulator=0.
  - in_ready=0 while rst_n is low, 1 from the first edge after deassertion.
  - out_valid=0, out_mask=0, out_count=0, err_range=0.
- Beat transfer: a beat transfers when in_valid && in_ready at the rising edge.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - On transfer with in_none=0 and in_pos<WIDTH: acc <= acc | (1<<in_pos).
  - On transfer with in_none=1: acc unchanged.
  - On transfer with in_pos>=WIDTH (only possible when WIDTH is not a power of 2): acc unchanged and err_range<=1.
  - Transfer with in_last=1: out_mask <= the final OR including this beat; out_count <= popcount of that value; acc <= 0; go to OUTPUT.
  - Latency: out_valid rises the cycle after the last beat transfers.
- State OUTPUT:
  - out_valid=1, in_ready=0.
  - out_mask and out_count are held stable until the handshake.
  - On out_valid && out_ready: go to ACCUM; in_ready=1 on the next cycle.
  - Throughput: one mask per (beats + 1) cycles at best.
- Boundary conditions:
  - A single-beat frame (in_last on the first beat) is legal.
  - An in_none+in_last frame produces out_mask=0, out_count=0.
  - Repeated positions within a frame are idempotent: the bit stays set and out_count counts distinct bits.
  - out_count is at most WIDTH, so it is POS_W+1 bits wide.
- in_valid low in ACCUM holds state indefinitely; no timeout.
- Changes on in_* while in_ready=0 are ignored.
- Reset asserted mid-frame or while in OUTPUT discards the partial/pending mask immediately; no output is produced for that frame.
- Outputs are registered; no combinational path from in_* to out_*. in_ready depends only on state.

Optional Feature:
- Macro POS_DUP_DETECT_EN.
- When defined:
  - Adds output port out_dup (1 bit, reset 0).
  - Internally tracks whether any transferred position in the frame targets a bit already set in acc, or already set by an earlier beat of the same frame.
  - out_dup is registered alongside out_mask, valid with out_valid, and cleared when the frame starts.
- When undefined:
  - Port out_dup is absent.
  - No duplicate-tracking logic; all other behaviour is identical.

Test Plan:
- Reset, then frame pos 1, 4, 7 (last on 7), out_ready=1 -> one cycle after last: out_valid=1, out_mask=8'b1001_0010, out_count=3; in_ready returns to 1 the cycle after the handshake.
- Single beat in_none=1,in_last=1 -> out_mask=8'h00, out_count=0.
- Frame pos 3, 3, 0 (last) -> out_mask=8'h09, out_count=2; with POS_DUP_DETECT_EN out_dup=1, else port absent.
- Backpressure: complete frame pos 5, hold out_ready=0 for 10 cycles -> out_valid stays 1, out_mask=8'h20 stable, in_ready=0, extra input beats are not taken. Release -> next frame (pos 2 last) yields 8'h04, with no leftover 0x20.
- WIDTH=6, in_pos=6 then pos 0 last -> err_range=1 and stays set, out_mask=6'b000001.
- Mid-frame reset after pos 2, 6, then frame pos 1 last -> single output mask 8'h02; no output for the aborted frame.

Source files
------------

// File: rtl/pos_to_mask_builder_if.sv
// rtl/pos_to_mask_builder_if.sv - position-beat input and rebuilt-mask output bundle for pos_to_mask_builder
interface pos_to_mask_builder_if #(
    parameter int WIDTH = 8,
    parameter int POS_W = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [POS_W-1:0] in_pos;
    logic             in_none;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_mask;
    logic [POS_W:0]   out_count;
    logic             err_range;
`ifdef POS_DUP_DETECT_EN
    logic             out_dup;
`endif

    modport slave (
        input  in_valid, in_pos, in_none, in_last, out_ready,
        output in_ready, out_valid, out_mask, out_count, err_range
`ifdef POS_DUP_DETECT_EN
        , output out_dup
`endif
    );

    modport master (
        output in_valid, in_pos, in_none, in_last, out_ready,
        input  in_ready, out_valid, out_mask, out_count, err_range
`ifdef POS_DUP_DETECT_EN
        , input out_dup
`endif
    );
endinterface

// File: rtl/pos_to_mask_builder.sv
// rtl/pos_to_mask_builder.sv - rebuilds a WIDTH-bit mask from a framed stream of bit positions (option POS_DUP_DETECT_EN adds out_dup)
module pos_to_mask_builder #(
    parameter int WIDTH = 8,
    parameter int POS_W = $clog2(WIDTH)
) (
    input logic                 clk,
    input logic                 rst_n,
    pos_to_mask_builder_if.slave bus
);

    typedef enum logic {S_ACCUM, S_OUTPUT} state_t;

    state_t           state, state_nxt;
    logic             in_ready_q, out_valid_q;
    logic             take, give, in_range;
    logic [WIDTH-1:0] acc, onehot, acc_nxt, out_mask_q;
    logic [POS_W:0]   out_count_q;
    logic             err_q;

    function automatic logic [POS_W:0] popcount(input logic [WIDTH-1:0] v);
        logic [POS_W:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) n = n + {{POS_W{1'b0}}, v[i]};
        return n;
    endfunction

    // Out-of-range positions only exist when WIDTH is not a power of two.
    if (WIDTH < (1 << POS_W)) begin : g_range
        assign in_range = (bus.in_pos < POS_W'(WIDTH));
    end else begin : g_full
        assign in_range = 1'b1;
    end

    assign take   = bus.in_valid && in_ready_q;
    assign give   = out_valid_q && bus.out_ready;
    assign onehot = (!bus.in_none && in_range) ? (WIDTH'(1) << bus.in_pos) : '0;
    assign acc_nxt = acc | onehot;

    always_comb begin
        state_nxt = state;
        case (state)
            S_ACCUM:  if (take && bus.in_last) state_nxt = S_OUTPUT;
            S_OUTPUT: if (give) state_nxt = S_ACCUM;
            default:  state_nxt = S_ACCUM;
        endcase
    end

    // Handshake flags are registered from the next state so in_ready stays low during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_ACCUM;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            in_ready_q  <= (state_nxt == S_ACCUM);
            out_valid_q <= (state_nxt == S_OUTPUT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            out_mask_q  <= '0;
            out_count_q <= '0;
            err_q       <= 1'b0;
        end else if (take) begin
            if (!bus.in_none && !in_range) err_q <= 1'b1;
            if (bus.in_last) begin
                out_mask_q  <= acc_nxt;
                out_count_q <= popcount(acc_nxt);
                acc         <= '0;
            end else begin
                acc <= acc_nxt;
            end
        end
    end

`ifdef POS_DUP_DETECT_EN
    logic dup_acc, out_dup_q, hit;

    // acc holds every bit set earlier in this frame, so overlap means a repeat.
    assign hit = |(acc & onehot);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dup_acc   <= 1'b0;
            out_dup_q <= 1'b0;
        end else if (take) begin
            if (bus.in_last) begin
                out_dup_q <= dup_acc | hit;
                dup_acc   <= 1'b0;
            end else begin
                dup_acc <= dup_acc | hit;
            end
        end
    end

    assign bus.out_dup = out_dup_q;
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_mask  = out_mask_q;
    assign bus.out_count = out_count_q;
    assign bus.err_range = err_q;

endmodule

// File: tb/tb_pos_to_mask_builder.sv
// tb/tb_pos_to_mask_builder.sv - randomized self-checking bench for pos_to_mask_builder (WIDTH=8 and WIDTH=6)
module tb_pos_to_mask_builder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pos_to_mask_builder_if #(.WIDTH(8)) if8 ();
    pos_to_mask_builder_if #(.WIDTH(6)) if6 ();

    pos_to_mask_builder #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    pos_to_mask_builder #(.WIDTH(6)) u6 (.clk(clk), .rst_n(rst_n), .bus(if6.slave));

    int checks = 0;
    int errors = 0;

    // Reference: a frame is the set of positions seen; the mask is that set.
    bit          seen [8];
    int unsigned m_mask;
    bit          m_dup;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) seen[i] = 1'b0;
        m_mask = 0;
        m_dup  = 1'b0;
    endtask

    task automatic model_beat(input int pos, input bit none);
        if (!none) begin
            if (seen[pos]) m_dup = 1'b1;
            seen[pos] = 1'b1;
            m_mask = m_mask | (32'd1 << pos);
        end
    endtask

    // Returns at the falling edge following the transfer edge.
    task automatic send(input bit w6, input int pos, input bit none, input bit last);
        int  n;
        logic rdy;
        n = 0;
        @(negedge clk);
        if (w6) begin
            if6.in_valid = 1'b1; if6.in_pos = 3'(pos); if6.in_none = none; if6.in_last = last;
        end else begin
            if8.in_valid = 1'b1; if8.in_pos = 3'(pos); if8.in_none = none; if8.in_last = last;
        end
        rdy = w6 ? if6.in_ready : if8.in_ready;
        while (!rdy && n < 50) begin
            @(negedge clk);
            n++;
            rdy = w6 ? if6.in_ready : if8.in_ready;
        end
        if (!rdy) check("in_ready_timeout", 32'(rdy), 32'd1);
        @(negedge clk);
        if6.in_valid = 1'b0;
        if8.in_valid = 1'b0;
    endtask

    task automatic expect_frame(input int hold);
        check("out_valid_latency", 32'(if8.out_valid), 32'd1);
        check("in_ready_busy", 32'(if8.in_ready), 32'd0);
        check("out_mask", 32'(if8.out_mask), m_mask);
        check("out_count", 32'(if8.out_count), 32'($countones(m_mask)));
`ifdef POS_DUP_DETECT_EN
        check("out_dup", 32'(if8.out_dup), 32'(m_dup));
`endif
        repeat (hold) begin
            @(negedge clk);
            check("hold_valid", 32'(if8.out_valid), 32'd1);
            check("hold_mask", 32'(if8.out_mask), m_mask);
        end
        if8.out_ready = 1'b1;
        @(negedge clk);
        if8.out_ready = 1'b0;
        check("valid_drop", 32'(if8.out_valid), 32'd0);
        check("in_ready_back", 32'(if8.in_ready), 32'd1);
        model_reset();
    endtask

    initial begin
        int nb, pos;
        bit none;
        if8.in_valid = 1'b0; if8.in_pos = '0; if8.in_none = 1'b0; if8.in_last = 1'b0; if8.out_ready = 1'b0;
        if6.in_valid = 1'b0; if6.in_pos = '0; if6.in_none = 1'b0; if6.in_last = 1'b0; if6.out_ready = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(if8.in_ready), 32'd0);
        check("rst_out_valid", 32'(if8.out_valid), 32'd0);
        check("rst_out_mask", 32'(if8.out_mask), 32'd0);
        check("rst_out_count", 32'(if8.out_count), 32'd0);
        check("rst_err", 32'(if8.err_range), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", 32'(if8.in_ready), 32'd1);

        // Directed frame 1, 4, 7.
        model_beat(1, 0); send(0, 1, 0, 0);
        model_beat(4, 0); send(0, 4, 0, 0);
        model_beat(7, 0); send(0, 7, 0, 1);
        check("frame147_mask", 32'(if8.out_mask), 32'h92);
        expect_frame(0);

        // Empty frame.
        send(0, 5, 1, 1);
        check("none_mask", 32'(if8.out_mask), 32'h00);
        expect_frame(1);

        // Repeated position.
        model_beat(3, 0); send(0, 3, 0, 0);
        model_beat(3, 0); send(0, 3, 0, 0);
        model_beat(0, 0); send(0, 0, 0, 1);
        check("dup_frame_count", 32'(if8.out_count), 32'd2);
        expect_frame(2);

        // Backpressure while extra beats are offered.
        model_beat(5, 0); send(0, 5, 0, 1);
        if8.in_valid = 1'b1; if8.in_pos = 3'd3; if8.in_none = 1'b0; if8.in_last = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("bp_valid", 32'(if8.out_valid), 32'd1);
            check("bp_mask", 32'(if8.out_mask), 32'h20);
            check("bp_in_ready", 32'(if8.in_ready), 32'd0);
        end
        if8.in_valid = 1'b0;
        expect_frame(0);
        model_beat(2, 0); send(0, 2, 0, 1);
        check("after_bp_mask", 32'(if8.out_mask), 32'h04);
        expect_frame(0);

        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            nb = $urandom_range(1, 5);
            for (int b = 0; b < nb; b++) begin
                none = ($urandom_range(0, 7) == 0);
                pos  = $urandom_range(0, 7);
                model_beat(pos, none);
                send(0, pos, none, (b == nb - 1));
            end
            expect_frame($urandom_range(0, 3));
        end

        // Reset in the middle of a frame.
        send(0, 2, 0, 0);
        send(0, 6, 0, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(if8.in_ready), 32'd0);
        check("midrst_out_valid", 32'(if8.out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_in_ready", 32'(if8.in_ready), 32'd1);
        check("postrst_out_valid", 32'(if8.out_valid), 32'd0);
        model_reset();
        model_beat(1, 0); send(0, 1, 0, 1);
        check("postrst_mask", 32'(if8.out_mask), 32'h02);
        expect_frame(0);

        // WIDTH=6: out-of-range position.
        send(1, 6, 0, 0);
        check("w6_err_set", 32'(if6.err_range), 32'd1);
        send(1, 0, 0, 1);
        check("w6_valid", 32'(if6.out_valid), 32'd1);
        check("w6_mask", 32'(if6.out_mask), 32'h01);
        check("w6_count", 32'(if6.out_count), 32'd1);
        if6.out_ready = 1'b1;
        @(negedge clk);
        if6.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("w6_valid_drop", 32'(if6.out_valid), 32'd0);
        check("w6_err_sticky", 32'(if6.err_range), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
